// File: rtl/timekeeper_counter.sv
// Parametrised min:sec timekeeper with run/pause/adjust/done control, preset load,
// single-clock tick enables and a blink phase for the field being adjusted.
module timekeeper_counter #(
    parameter int BASE_CLK = 100_000_000,
    parameter int RUN_HZ   = 1,
    parameter int ADJ_HZ   = 2,
    parameter int SEC_MAX  = 60,
    parameter int MIN_MAX  = 60,
    parameter int CNT_W    = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adj,
    input  logic             i_sel,
    input  logic             i_dir,
    input  logic             i_pause,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_min,
    input  logic [CNT_W-1:0] i_load_sec,
    output logic [CNT_W-1:0] o_minutes,
    output logic [CNT_W-1:0] o_seconds,
    output logic             o_tick,
    output logic             o_wrap,
    output logic             o_done,
    output logic             o_blink
);
    localparam int RUN_DIV = BASE_CLK / RUN_HZ;
    localparam int ADJ_DIV = BASE_CLK / ADJ_HZ;
    localparam int RUN_W   = $clog2(RUN_DIV);
    localparam int ADJ_W   = $clog2(ADJ_DIV);
    localparam logic [RUN_W-1:0] RUN_TOP = RUN_W'(RUN_DIV - 1);
    localparam logic [ADJ_W-1:0] ADJ_TOP = ADJ_W'(ADJ_DIV - 1);
    localparam logic [CNT_W:0]   SEC_LIM = (CNT_W+1)'(SEC_MAX);
    localparam logic [CNT_W:0]   MIN_LIM = (CNT_W+1)'(MIN_MAX);
    localparam logic [CNT_W-1:0] SEC_TOP = CNT_W'(SEC_MAX - 1);
    localparam logic [CNT_W-1:0] MIN_TOP = CNT_W'(MIN_MAX - 1);

    typedef enum logic [1:0] {RUN, PAUSED, ADJUST, DONE} state_t;
    typedef struct packed {
        logic [CNT_W-1:0] min;
        logic [CNT_W-1:0] sec;
    } mmss_t;

    state_t           state, nxt_state;
    mmss_t            cnt, nxt_cnt, preset;
    logic [RUN_W-1:0] run_cnt;
    logic [ADJ_W-1:0] adj_cnt;
    logic             run_tick, adj_tick, wrap_evt;

    function automatic logic [CNT_W-1:0] inc_mod(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] top);
        return (v == top) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] dec_mod(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] top);
        return (v == '0) ? top : v - 1'b1;
    endfunction

    assign run_tick   = (state == RUN) && (run_cnt == RUN_TOP);
    assign adj_tick   = (state == ADJUST) && (adj_cnt == ADJ_TOP);
    assign preset.sec = ({1'b0, i_load_sec} >= SEC_LIM) ? SEC_TOP : i_load_sec;
    assign preset.min = ({1'b0, i_load_min} >= MIN_LIM) ? MIN_TOP : i_load_min;
    assign o_minutes  = cnt.min;
    assign o_seconds  = cnt.sec;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        wrap_evt  = 1'b0;
        if (i_load) nxt_cnt = preset;
        case (state)
            RUN: begin
                if (i_adj) nxt_state = ADJUST;
                else if (i_load) nxt_state = (i_dir && preset == '0) ? DONE : RUN;
                else if (i_pause) nxt_state = PAUSED;
                else if (run_tick) begin
                    if (!i_dir) begin
                        nxt_cnt.sec = inc_mod(cnt.sec, SEC_TOP);
                        if (cnt.sec == SEC_TOP) begin
                            nxt_cnt.min = inc_mod(cnt.min, MIN_TOP);
                            wrap_evt    = (cnt.min == MIN_TOP);
                        end
                    end else begin
                        nxt_cnt.sec = dec_mod(cnt.sec, SEC_TOP);
                        if (cnt.sec == '0) nxt_cnt.min = dec_mod(cnt.min, MIN_TOP);
                        if (nxt_cnt == '0) nxt_state = DONE;
                    end
                end
            end
            PAUSED: begin
                if (i_adj) nxt_state = ADJUST;
                else if (!i_load && i_pause) nxt_state = RUN;
            end
            ADJUST: begin
                // exit decision looks at the post-load count so a same-cycle load of 00:00 lands in DONE
                if (!i_adj) nxt_state = (i_dir && nxt_cnt == '0) ? DONE : RUN;
                else if (!i_load && adj_tick) begin
                    if (i_sel) nxt_cnt.min = inc_mod(cnt.min, MIN_TOP);
                    else       nxt_cnt.sec = inc_mod(cnt.sec, SEC_TOP);
                end
            end
            DONE: begin
                if (i_adj) nxt_state = ADJUST;
                else if (i_load) nxt_state = (i_dir && preset == '0) ? DONE : RUN;
                else if (!i_dir) nxt_state = RUN;
            end
            default: nxt_state = RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= RUN;
            cnt     <= '0;
            run_cnt <= '0;
            adj_cnt <= '0;
            o_tick  <= 1'b0;
            o_wrap  <= 1'b0;
            o_done  <= 1'b0;
            o_blink <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            // prescalers restart from 0 whenever their state is (re)entered
            run_cnt <= (state == RUN && nxt_state == RUN && !i_load && !run_tick)
                       ? run_cnt + 1'b1 : '0;
            adj_cnt <= (state == ADJUST && nxt_state == ADJUST && !adj_tick)
                       ? adj_cnt + 1'b1 : '0;
            o_tick  <= (nxt_cnt != cnt);
            o_wrap  <= wrap_evt;
            o_done  <= (nxt_state == DONE);
            o_blink <= (nxt_state == ADJUST) ? (o_blink ^ adj_tick) : 1'b0;
        end
    end
endmodule

// File: tb/tb_timekeeper_counter.sv
// Directed bench for timekeeper_counter: 20-cycle run tick, 10-cycle adjust tick.
module tb_timekeeper_counter;
    logic       i_clk = 1'b0;
    logic       i_rst_n, i_adj, i_sel, i_dir, i_pause, i_load;
    logic [5:0] i_load_min, i_load_sec;
    logic [5:0] o_minutes, o_seconds;
    logic       o_tick, o_wrap, o_done, o_blink;

    int checks = 0;
    int errors = 0;
    int n_tick = 0;
    int n_wrap = 0;

    timekeeper_counter #(
        .BASE_CLK(20), .RUN_HZ(1), .ADJ_HZ(2), .SEC_MAX(60), .MIN_MAX(60), .CNT_W(6)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_adj(i_adj), .i_sel(i_sel), .i_dir(i_dir),
        .i_pause(i_pause), .i_load(i_load), .i_load_min(i_load_min),
        .i_load_sec(i_load_sec), .o_minutes(o_minutes), .o_seconds(o_seconds),
        .o_tick(o_tick), .o_wrap(o_wrap), .o_done(o_done), .o_blink(o_blink)
    );

    always #5 i_clk = ~i_clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            if (o_tick) n_tick++;
            if (o_wrap) n_wrap++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] m, input logic [5:0] s);
        i_load_min = m;
        i_load_sec = s;
        i_load     = 1'b1;
        step(1);
        i_load     = 1'b0;
    endtask

    task automatic pulse_pause();
        i_pause = 1'b1;
        step(1);
        i_pause = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0; i_adj = 1'b0; i_sel = 1'b0; i_dir = 1'b0;
        i_pause = 1'b0; i_load = 1'b0; i_load_min = '0; i_load_sec = '0;
        step(2);
        chk("rst_min", o_minutes, 0);
        chk("rst_sec", o_seconds, 0);
        chk("rst_flags", {o_tick, o_wrap, o_done, o_blink}, 0);
        i_rst_n = 1'b1;

        // free-running up count from reset
        step(19);
        chk("up_pre_sec", o_seconds, 0);
        step(1);
        chk("up_first_sec", o_seconds, 1);
        chk("up_first_tick", o_tick, 1);
        step(1);
        chk("tick_width", o_tick, 0);
        step(1259);
        chk("up_1280_min", o_minutes, 1);
        chk("up_1280_sec", o_seconds, 4);
        chk("up_tick_cnt", n_tick, 64);

        // full rollover
        load(59, 59);
        n_wrap = 0;
        step(19);
        chk("wrap_pre_sec", o_seconds, 59);
        step(1);
        chk("wrap_min", o_minutes, 0);
        chk("wrap_sec", o_seconds, 0);
        chk("wrap_pulse", o_wrap, 1);
        chk("wrap_done", o_done, 0);
        step(1);
        chk("wrap_width", o_wrap, 0);
        chk("wrap_cnt", n_wrap, 1);

        // countdown to DONE
        i_dir = 1'b1;
        load(1, 2);
        n_tick = 0;
        step(20);
        chk("dn_1_sec", o_seconds, 1);
        step(20);
        chk("dn_2", {o_minutes, o_seconds}, {6'd1, 6'd0});
        step(20);
        chk("dn_3", {o_minutes, o_seconds}, {6'd0, 6'd59});
        step(1180);
        chk("dn_zero", {o_minutes, o_seconds}, 0);
        chk("dn_done", o_done, 1);
        chk("dn_tick_cnt", n_tick, 62);
        pulse_pause();
        step(99);
        chk("done_hold", {o_minutes, o_seconds}, 0);
        chk("done_level", o_done, 1);
        chk("done_no_tick", n_tick, 62);
        load(0, 5);
        chk("done_load_sec", o_seconds, 5);
        chk("done_load_exit", o_done, 0);
        step(20);
        chk("done_load_run", o_seconds, 4);

        // adjust minutes from 58:10
        i_dir = 1'b0;
        load(58, 10);
        i_adj = 1'b1; i_sel = 1'b1;
        step(1);
        chk("adj_entry_blink", o_blink, 0);
        step(9);
        chk("adj_pre_min", o_minutes, 58);
        step(1);
        chk("adj_min_59", o_minutes, 59);
        chk("adj_blink_1", o_blink, 1);
        step(10);
        chk("adj_min_00", o_minutes, 0);
        chk("adj_blink_2", o_blink, 0);
        step(10);
        chk("adj_min_01", o_minutes, 1);
        step(10);
        chk("adj_min_02", o_minutes, 2);
        chk("adj_sec_kept", o_seconds, 10);
        i_adj = 1'b0;
        step(1);
        chk("adj_exit_blink", o_blink, 0);
        step(20);
        chk("adj_resume", {o_minutes, o_seconds}, {6'd2, 6'd11});

        // pause
        load(0, 7);
        pulse_pause();
        n_tick = 0;
        step(100);
        chk("pause_hold", o_seconds, 7);
        chk("pause_no_tick", n_tick, 0);
        pulse_pause();
        step(19);
        chk("resume_pre", o_seconds, 7);
        step(1);
        chk("resume_sec", o_seconds, 8);

        // clamp, then async reset mid-count
        load(63, 63);
        chk("clamp", {o_minutes, o_seconds}, {6'd59, 6'd59});
        step(5);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", {o_minutes, o_seconds}, 0);
        chk("async_rst_flags", {o_tick, o_wrap, o_done, o_blink}, 0);
        step(1);
        i_rst_n = 1'b1;
        step(19);
        chk("post_rst_pre", o_seconds, 0);
        step(1);
        chk("post_rst_run", o_seconds, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
